// File: rtl/mux_rr_lanes.sv
// mux_rr_lanes -- N:1 lane-merging mux onto one registered output stream.
//
// Two selection modes, chosen at elaboration time:
//   SKIP_INVALID=0 : fixed time-slot rotation. Every enabled cycle serves the
//                    next slot, whether or not that lane is valid.
//   SKIP_INVALID=1 : round-robin over valid lanes only. Idle lanes use no slots.
// Each output word is tagged with its source lane and a frame-start marker
// (lane/slot 0) so that the receive-side demux can realign.
//
// Ports
//   clk_4f    in   fast clock; all state changes on its rising edge
//   reset_L   in   asynchronous active-low reset
//   enable    in   1 = rotate and sample; 0 = freeze the selector
//   data_in   in   LANES*DATA_W; lane k sits at [k*DATA_W +: DATA_W]
//   valid_in  in   per-lane valid
//   data_out  out  registered merged word
//   valid_out out  registered; data_out carries a live word
//   lane_out  out  registered; source lane of the current data_out
//   sof_out   out  registered; word came from slot/lane 0
module mux_rr_lanes #(
  parameter  int DATA_W       = 8,
  parameter  int LANES        = 4,
  parameter  int SKIP_INVALID = 0,
  parameter  int HOLD_ON_IDLE = 1,
  localparam int LW           = $clog2(LANES)
) (
  input  logic                    clk_4f,
  input  logic                    reset_L,
  input  logic                    enable,
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic [LANES-1:0]        valid_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  output logic [LW-1:0]           lane_out,
  output logic                    sof_out
);

  // Packed view of the input bus: lane_data[k] == data_in[k*DATA_W +: DATA_W].
  logic [LANES-1:0][DATA_W-1:0] lane_data;
  assign lane_data = data_in;

  logic [LW-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              sof_q, sof_d;

  logic [LW-1:0]     pick;
  logic              hit;
  logic [LW:0]       cand;

  // Explicit wrap so a non-power-of-2 LANES never reaches an illegal index.
  function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] x);
    return (x == LW'(LANES-1)) ? '0 : x + 1'b1;
  endfunction

  // Lane selection. Time-slot mode always picks sel; round-robin mode scans
  // sel, sel+1, ... (mod LANES) and takes the first valid lane.
  always_comb begin
    pick = sel_q;
    hit  = 1'b0;
    cand = '0;
    if (SKIP_INVALID == 0) begin
      hit = valid_in[sel_q];
    end else begin
      for (int i = 0; i < LANES; i++) begin
        cand = {1'b0, sel_q} + (LW+1)'(i);
        if (cand >= (LW+1)'(LANES)) cand = cand - (LW+1)'(LANES);
        if (!hit && valid_in[cand[LW-1:0]]) begin
          hit  = 1'b1;
          pick = cand[LW-1:0];
        end
      end
    end
  end

  always_comb begin
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    lane_d  = lane_q;
    sof_d   = 1'b0;
    if (enable) begin
      valid_d = hit;
      if (hit)                    data_d = lane_data[pick];
      else if (HOLD_ON_IDLE == 0) data_d = '0;
      if (SKIP_INVALID == 0) begin
        // The slot advances and is tagged even when its lane is idle.
        lane_d = sel_q;
        sof_d  = (sel_q == '0);
        sel_d  = wrap_inc(sel_q);
      end else if (hit) begin
        // Restart the scan just past the lane served, which bounds the
        // wait of any continuously valid lane to LANES enabled cycles.
        lane_d = pick;
        sof_d  = (pick == '0);
        sel_d  = wrap_inc(pick);
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lane_q  <= '0;
      sof_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      sof_q   <= sof_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign lane_out  = lane_q;
  assign sof_out   = sof_q;

endmodule

// File: tb/tb_mux_rr_lanes.sv
// Bench for mux_rr_lanes: five configurations share one stimulus stream.
//   d0: LANES=4 time-slot HOLD=1   d1: LANES=4 time-slot HOLD=0
//   d2: LANES=4 round-robin HOLD=1 d3: LANES=3 time-slot HOLD=1
//   d4: LANES=3 round-robin HOLD=0
module tb_mux_rr_lanes;
  localparam int ND = 5;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] d;
    logic       v;
    logic [1:0] l;
    logic       s;
  } st_t;
  typedef st_t [ND-1:0] all_t;

  logic gclk = 1'b0;
  logic grst_n = 1'b1;
  logic en = 1'b0;
  logic [31:0] din = '0;
  logic [3:0]  vin = '0;

  logic [ND-1:0][7:0] dout;
  logic [ND-1:0]      vout;
  logic [ND-1:0][1:0] lout;
  logic [ND-1:0]      sout;

  int nchk = 0;
  int nerr = 0;
  all_t ms;
  all_t sb[$];

  always #5 gclk = ~gclk;

  mux_rr_lanes #(.DATA_W(8), .LANES(4), .SKIP_INVALID(0), .HOLD_ON_IDLE(1)) u_d0 (
    .clk_4f(gclk), .reset_L(grst_n), .enable(en), .data_in(din), .valid_in(vin),
    .data_out(dout[0]), .valid_out(vout[0]), .lane_out(lout[0]), .sof_out(sout[0]));
  mux_rr_lanes #(.DATA_W(8), .LANES(4), .SKIP_INVALID(0), .HOLD_ON_IDLE(0)) u_d1 (
    .clk_4f(gclk), .reset_L(grst_n), .enable(en), .data_in(din), .valid_in(vin),
    .data_out(dout[1]), .valid_out(vout[1]), .lane_out(lout[1]), .sof_out(sout[1]));
  mux_rr_lanes #(.DATA_W(8), .LANES(4), .SKIP_INVALID(1), .HOLD_ON_IDLE(1)) u_d2 (
    .clk_4f(gclk), .reset_L(grst_n), .enable(en), .data_in(din), .valid_in(vin),
    .data_out(dout[2]), .valid_out(vout[2]), .lane_out(lout[2]), .sof_out(sout[2]));
  mux_rr_lanes #(.DATA_W(8), .LANES(3), .SKIP_INVALID(0), .HOLD_ON_IDLE(1)) u_d3 (
    .clk_4f(gclk), .reset_L(grst_n), .enable(en), .data_in(din[23:0]), .valid_in(vin[2:0]),
    .data_out(dout[3]), .valid_out(vout[3]), .lane_out(lout[3]), .sof_out(sout[3]));
  mux_rr_lanes #(.DATA_W(8), .LANES(3), .SKIP_INVALID(1), .HOLD_ON_IDLE(0)) u_d4 (
    .clk_4f(gclk), .reset_L(grst_n), .enable(en), .data_in(din[23:0]), .valid_in(vin[2:0]),
    .data_out(dout[4]), .valid_out(vout[4]), .lane_out(lout[4]), .sof_out(sout[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lanes_of(input int i);
    return (i >= 3) ? 3 : 4;
  endfunction
  function automatic bit skip_of(input int i);
    return (i == 2) || (i == 4);
  endfunction
  function automatic bit hold_of(input int i);
    return (i != 1) && (i != 4);
  endfunction

  // Reference behaviour, one enabled/disabled clock at a time.
  function automatic st_t mdl(input st_t c, input int i, input logic e,
                              input logic [31:0] di, input logic [3:0] vi);
    st_t n;
    int  ln, k, p;
    n  = c;
    ln = lanes_of(i);
    k  = int'(c.sel);
    p  = -1;
    if (!e) begin
      n.v = 1'b0;
      n.s = 1'b0;
      return n;
    end
    if (!skip_of(i)) begin
      n.v   = vi[k];
      n.l   = c.sel;
      n.s   = (k == 0);
      n.d   = vi[k] ? di[k*8 +: 8] : (hold_of(i) ? c.d : 8'h00);
      n.sel = 2'((k + 1) % ln);
    end else begin
      for (int j = 0; j < ln; j++)
        if (p < 0 && vi[(k + j) % ln]) p = (k + j) % ln;
      if (p < 0) begin
        n.v = 1'b0;
        n.s = 1'b0;
        if (!hold_of(i)) n.d = 8'h00;
      end else begin
        n.v   = 1'b1;
        n.d   = di[p*8 +: 8];
        n.l   = 2'(p);
        n.s   = (p == 0);
        n.sel = 2'((p + 1) % ln);
      end
    end
    return n;
  endfunction

  task automatic step();
    all_t e;
    for (int i = 0; i < ND; i++) e[i] = mdl(ms[i], i, en, din, vin);
    ms = e;
    sb.push_back(e);
    @(posedge gclk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      for (int i = 0; i < ND; i++) begin
        chk($sformatf("d%0d_data", i), 32'(dout[i]), 32'(e[i].d));
        chk($sformatf("d%0d_valid", i), 32'(vout[i]), 32'(e[i].v));
        chk($sformatf("d%0d_lane", i), 32'(lout[i]), 32'(e[i].l));
        chk($sformatf("d%0d_sof", i), 32'(sout[i]), 32'(e[i].s));
        if (i >= 3) chk($sformatf("d%0d_lane_lt3", i), 32'(lout[i] < 2'd3), 32'd1);
      end
    end
  endtask

  // Async reset asserted between edges; outputs must clear before any clock.
  task automatic do_reset();
    #2;
    grst_n = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("rst_d%0d_data", i), 32'(dout[i]), 32'd0);
      chk($sformatf("rst_d%0d_valid", i), 32'(vout[i]), 32'd0);
      chk($sformatf("rst_d%0d_lane", i), 32'(lout[i]), 32'd0);
      chk($sformatf("rst_d%0d_sof", i), 32'(sout[i]), 32'd0);
    end
    ms = '0;
    sb.delete();
    @(posedge gclk);
    #3;
    grst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e0 [4];
    logic [7:0] e1 [4];
    e0 = '{8'h11, 8'h11, 8'h33, 8'h33};
    e1 = '{8'h11, 8'h00, 8'h33, 8'h00};
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    vin = 4'hF;
    en  = 1'b1;
    #1;
    do_reset();

    // Reset mid-stream with all lanes valid, then first word is lane 0.
    repeat (5) step();
    do_reset();
    step();
    chk("t1_first_lane", 32'(lout[0]), 32'd0);
    chk("t1_first_sof", 32'(sout[0]), 32'd1);
    chk("t1_first_data", 32'(dout[0]), 32'h11);
    repeat (8) step();

    // Time-slot with valid 0101: hold vs zero on idle slots.
    do_reset();
    vin = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t3_hold_data", 32'(dout[0]), 32'(e0[c]));
      chk("t3_zero_data", 32'(dout[1]), 32'(e1[c]));
      chk("t3_valid", 32'(vout[0]), 32'((c % 2) == 0));
    end

    // Round-robin with valid 1010: 22,44 every cycle, no sof.
    do_reset();
    vin = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t4_data", 32'(dout[2]), (c % 2 == 0) ? 32'h22 : 32'h44);
      chk("t4_lane", 32'(lout[2]), (c % 2 == 0) ? 32'd1 : 32'd3);
      chk("t4_sof", 32'(sout[2]), 32'd0);
      chk("t4_valid", 32'(vout[2]), 32'd1);
    end

    // Round-robin idle for 3 cycles, then lane 2 only.
    vin = 4'b0000;
    repeat (3) begin
      step();
      chk("t5_idle_valid", 32'(vout[2]), 32'd0);
    end
    vin = 4'b0100;
    step();
    chk("t5_data", 32'(dout[2]), 32'h33);
    chk("t5_lane", 32'(lout[2]), 32'd2);

    // Enable freeze and resume, all lanes valid.
    do_reset();
    vin = 4'hF;
    repeat (4) step();
    en = 1'b0;
    repeat (2) begin
      step();
      chk("t6_frz_valid", 32'(vout[3]), 32'd0);
      chk("t6_frz_lane", 32'(lout[3]), 32'd0);
    end
    en = 1'b1;
    step();
    chk("t6_resume_lane", 32'(lout[3]), 32'd1);
    repeat (4) step();

    // Random traffic with occasional freezes and a mid-stream reset.
    for (int c = 0; c < 150; c++) begin
      din = $urandom();
      vin = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 4) != 0);
      if (c == 75) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
    $finish;
  end
endmodule
